// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake and RAM signal around the arbiter.
// Pure wiring; no latency of its own.
// Backpressure is carried by the i_ready / d_ready lines inside the bundle.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    // instruction fetch requester
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_ready;
    logic                  i_rvalid;
    logic [31:0]           i_rdata;
    // load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_wmask;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic                  d_ready;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    // block RAM port
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters plus RAM side
    modport master (
        output i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one sync-read RAM between fetch and load/store.
// Read: ready in N, rvalid in N+1, next grant N+2. Store: written in N, next grant N+1.
// Requesters hold req until ready; no grant is issued while a read response is pending.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_RESP = 2'd1;
    localparam logic [1:0] D_RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_d_q, last_d_d;   // 1 = data side was served last
    logic       oor_q, oor_d;         // pending read targeted an out-of-range address
    logic       grant_i, grant_d;
    logic       i_oor, d_oor;

    // Byte-offset bits never reach the word-addressed RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    // Any address bit above the RAM's word range marks the access out of range.
    always_comb begin
        i_oor = |bus.i_addr[31:ADDR_WIDTH+2];
        d_oor = |bus.d_addr[31:ADDR_WIDTH+2];
    end

    // Arbitration, RAM drive and response muxing; everything is gated off in reset.
    always_comb begin
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        state_d       = IDLE;
        last_d_d      = last_d_q;
        oor_d         = 1'b0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.i_rdata   = 32'h0;
        bus.d_rdata   = 32'h0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'h0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;

        if (!reset && state_q == IDLE) begin
            // a tie goes to whichever side was not served last
            if (bus.i_req && (!bus.d_req || last_d_q)) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end
        end

        if (grant_i) begin
            bus.i_ready  = 1'b1;
            bus.mem_addr = bus.i_addr[ADDR_WIDTH+1:2];
            bus.mem_en   = !i_oor;
            state_d      = I_RESP;
            oor_d        = i_oor;
            last_d_d     = 1'b0;
        end

        if (grant_d) begin
            bus.d_ready  = 1'b1;
            bus.mem_addr = bus.d_addr[ADDR_WIDTH+1:2];
            last_d_d     = 1'b1;
            if (bus.d_we) begin
                // empty mask or out-of-range store is accepted but touches nothing
                bus.mem_en    = !d_oor && (|bus.d_wmask);
                bus.mem_we    = d_oor ? 4'h0 : bus.d_wmask;
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.mem_en = !d_oor;
                state_d    = D_RESP;
                oor_d      = d_oor;
            end
        end

        if (!reset && state_q == I_RESP) begin
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = oor_q ? 32'h0 : bus.mem_rdata;
        end

        if (!reset && state_q == D_RESP) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = oor_q ? 32'h0 : bus.mem_rdata;
        end
    end

    // State, fairness pointer and range flag; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            oor_q    <= oor_d;
        end
    end

endmodule
